// File: rtl/counter_bus_master_if.sv
// counter_bus_master_if
//   Bundles the command/response handshake of the engine together with the
//   pins that connect to the external counter chip.
//   Command side : cmd_valid, cmd_ready, cmd_op, cmd_addr, cmd_wdata,
//                  done, rsp_valid, rsp_rdata
//   Counter side : ncs, nwr, nrd, A0, A1, dout, bus_rdata, start
//   modport master : the bus engine (counter_bus_master)
//   modport slave  : whoever issues commands and models the counter
interface counter_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       done;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ncs;
  logic       nwr;
  logic       nrd;
  logic       A0;
  logic       A1;
  logic [7:0] dout;
  logic [7:0] bus_rdata;
  logic       start;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_rdata,
    output cmd_ready, done, rsp_valid, rsp_rdata,
    output ncs, nwr, nrd, A0, A1, dout, start
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_rdata,
    input  cmd_ready, done, rsp_valid, rsp_rdata,
    input  ncs, nwr, nrd, A0, A1, dout, start
  );
endinterface

// File: rtl/counter_bus_master.sv
// counter_bus_master
//   Turns single register commands into timed bus cycles towards an external
//   counter chip (chip select, write/read strobes, 2-bit address, 8-bit data)
//   and drives the counter's start input as a level.
//   Ports:
//     clk   - single clock, rising edge
//     reset - asynchronous, active-low
//     bus   - counter_bus_master_if.master (command handshake + counter pins)
//   Parameters SETUP_CYC / STROBE_CYC / HOLD_CYC (1..15) set the bus phase
//   lengths in clock cycles.
module counter_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_bus_master_if.master   bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, FINISH} state_t;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

  state_t     state_reg, state_next;
  logic [3:0] phase_reg, phase_next;
  logic [1:0] op_reg, op_next;
  logic [1:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic       start_reg, start_next;
  logic [7:0] rsp_rdata_reg, rsp_rdata_next;

  // Registered pin/handshake outputs, computed from the next state so every
  // output is a flop and therefore glitch-free.
  logic       ready_reg, ready_next;
  logic       ncs_reg, ncs_next;
  logic       nwr_reg, nwr_next;
  logic       nrd_reg, nrd_next;
  logic [1:0] a_reg, a_next;
  logic [7:0] dout_reg, dout_next;
  logic       done_reg, done_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic       busy_next;

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    start_next     = start_reg;
    rsp_rdata_next = rsp_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid && ready_reg) begin
          op_next    = bus.cmd_op;
          addr_next  = bus.cmd_addr;
          wdata_next = bus.cmd_wdata;
          phase_next = '0;
          if (bus.cmd_op[1]) begin
            // start set/clear: no bus cycle, just the level change
            start_next = ~bus.cmd_op[0];
            state_next = FINISH;
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        if (phase_reg == SETUP_LAST) begin
          state_next = STROBE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 4'd1;
        end
      end
      STROBE: begin
        if (phase_reg == STROBE_LAST) begin
          state_next = HOLD;
          phase_next = '0;
          // capture on the edge that ends the strobe, while the counter
          // still drives valid data
          if (op_reg == OP_RD) rsp_rdata_next = bus.bus_rdata;
        end else begin
          phase_next = phase_reg + 4'd1;
        end
      end
      HOLD: begin
        if (phase_reg == HOLD_LAST) begin
          state_next = FINISH;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 4'd1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next      = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    ready_next     = (state_next == IDLE);
    ncs_next       = ~busy_next;
    nwr_next       = ~((state_next == STROBE) && (op_next == OP_WR));
    nrd_next       = ~((state_next == STROBE) && (op_next == OP_RD));
    a_next         = busy_next ? addr_next : 2'b00;
    dout_next      = (busy_next && (op_next == OP_WR)) ? wdata_next : 8'h00;
    done_next      = (state_next == FINISH);
    rsp_valid_next = (state_next == FINISH) && (op_next == OP_RD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      op_reg        <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      start_reg     <= 1'b0;
      rsp_rdata_reg <= '0;
      ready_reg     <= 1'b1;
      ncs_reg       <= 1'b1;
      nwr_reg       <= 1'b1;
      nrd_reg       <= 1'b1;
      a_reg         <= '0;
      dout_reg      <= '0;
      done_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      op_reg        <= op_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      start_reg     <= start_next;
      rsp_rdata_reg <= rsp_rdata_next;
      ready_reg     <= ready_next;
      ncs_reg       <= ncs_next;
      nwr_reg       <= nwr_next;
      nrd_reg       <= nrd_next;
      a_reg         <= a_next;
      dout_reg      <= dout_next;
      done_reg      <= done_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  assign bus.cmd_ready = ready_reg;
  assign bus.done      = done_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.ncs       = ncs_reg;
  assign bus.nwr       = nwr_reg;
  assign bus.nrd       = nrd_reg;
  assign bus.A0        = a_reg[0];
  assign bus.A1        = a_reg[1];
  assign bus.dout      = dout_reg;
  assign bus.start     = start_reg;

endmodule

// File: tb/tb_counter_bus_master.sv
// tb_counter_bus_master
//   Two engines share one clock: u_dut0 with default timing and u_dut1 with
//   SETUP=3, STROBE=1, HOLD=2. Expected pin values per cycle come from a
//   timeline model: cycle k after acceptance is in setup, strobe or hold
//   purely by comparing k with the phase lengths.
module tb_counter_bus_master;

  localparam int S0 = 1, T0 = 2, H0 = 1;
  localparam int S1 = 3, T1 = 1, H1 = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  counter_bus_master_if bus0();
  counter_bus_master_if bus1();

  counter_bus_master u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  counter_bus_master #(.SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    bit       sel;
    bit [1:0] op;
    bit [1:0] addr;
    bit [7:0] wdata;
    bit [7:0] rd_strobe;
    bit [7:0] rd_hold;
    bit       junk;
    int       exp_lat;
    bit [7:0] exp_rsp;
  } vec_t;

  vec_t vecs[7];
  int   total = 0;
  int   passed = 0;
  bit   exp_start[2];
  bit [7:0] exp_rdata[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // {ready, start, done, rsp_valid, ncs, nwr, nrd, A1, A0, dout}
  function automatic logic [16:0] get_obs(input bit sel);
    if (sel)
      return {bus1.cmd_ready, bus1.start, bus1.done, bus1.rsp_valid, bus1.ncs,
              bus1.nwr, bus1.nrd, bus1.A1, bus1.A0, bus1.dout};
    return {bus0.cmd_ready, bus0.start, bus0.done, bus0.rsp_valid, bus0.ncs,
            bus0.nwr, bus0.nrd, bus0.A1, bus0.A0, bus0.dout};
  endfunction

  function automatic logic [16:0] idle_obs(input bit sel);
    return {1'b1, exp_start[sel], 2'b00, 3'b111, 2'b00, 8'h00};
  endfunction

  function automatic int bus_len(input bit sel);
    return sel ? (S1 + T1 + H1) : (S0 + T0 + H0);
  endfunction

  function automatic bit in_strobe(input bit sel, input bit [1:0] op, input int k);
    int s, t;
    s = sel ? S1 : S0;
    t = sel ? T1 : T0;
    return !op[1] && (k > s) && (k <= s + t);
  endfunction

  // Expected pins in cycle k (1 = first cycle after the acceptance edge).
  function automatic logic [16:0] model_obs(input bit sel, input int k, input bit [1:0] op,
                                            input bit [1:0] addr, input bit [7:0] wdata);
    int  l;
    bit  busy, strb, fin;
    l    = op[1] ? 1 : bus_len(sel) + 1;
    busy = !op[1] && (k <= bus_len(sel));
    strb = in_strobe(sel, op, k);
    fin  = (k == l);
    return {1'b0, exp_start[sel], fin, fin && (op == 2'b01), !busy,
            !(strb && op == 2'b00), !(strb && op == 2'b01),
            busy ? addr : 2'b00, (busy && op == 2'b00) ? wdata : 8'h00};
  endfunction

  task automatic drive(input bit sel, input bit v, input bit [1:0] op,
                       input bit [1:0] addr, input bit [7:0] wd);
    if (sel) begin
      bus1.cmd_valid = v; bus1.cmd_op = op; bus1.cmd_addr = addr; bus1.cmd_wdata = wd;
    end else begin
      bus0.cmd_valid = v; bus0.cmd_op = op; bus0.cmd_addr = addr; bus0.cmd_wdata = wd;
    end
  endtask

  task automatic set_rdata(input bit sel, input bit [7:0] d);
    if (sel) bus1.bus_rdata = d;
    else     bus0.bus_rdata = d;
  endtask

  task automatic run_cmd(input bit sel, input bit [1:0] op, input bit [1:0] addr,
                         input bit [7:0] wdata, input bit [7:0] rds, input bit [7:0] rdh,
                         input bit junk, input int exp_lat, input bit [7:0] exp_rsp,
                         input string name);
    int wt, l, lat;
    logic [16:0] o;
    @(negedge clk);
    wt = 0;
    while (!get_obs(sel)[16] && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check($sformatf("%s ready", name), 32'(get_obs(sel)[16]), 32'd1);
    drive(sel, 1'b1, op, addr, wdata);
    if (op == 2'b10) exp_start[sel] = 1'b1;
    if (op == 2'b11) exp_start[sel] = 1'b0;
    l   = op[1] ? 1 : bus_len(sel) + 1;
    lat = 0;
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      o = get_obs(sel);
      check($sformatf("%s c%0d", name, k), 32'(o), 32'(model_obs(sel, k, op, addr, wdata)));
      if (o[14] && lat == 0) lat = k;
      set_rdata(sel, in_strobe(sel, op, k) ? rds : rdh);
      if (junk && k < l) drive(sel, 1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
      else drive(sel, 1'b0, 2'($urandom), 2'($urandom), 8'($urandom));
    end
    @(negedge clk);
    check($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
    check($sformatf("%s rsp_rdata", name),
          32'(sel ? bus1.rsp_rdata : bus0.rsp_rdata), 32'(exp_rsp));
    check($sformatf("%s idle", name), 32'(get_obs(sel)), 32'(idle_obs(sel)));
    if (op == 2'b01) exp_rdata[sel] = rds;
  endtask

  initial begin
    bit [1:0] bop[6];
    bit [1:0] baddr[6];
    bit [7:0] bdat[6];
    int       acc[6];
    bit       ncs_q[$];
    bit       start_q[$];
    int       idx, cnt;
    bit       pending;

    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'h00);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 8'h00);
    set_rdata(1'b0, 8'h00);
    set_rdata(1'b1, 8'h00);
    exp_start = '{1'b0, 1'b0};
    exp_rdata = '{8'h00, 8'h00};

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("reset pins0", 32'(get_obs(1'b0)[15:0]), 32'({1'b0, 2'b00, 3'b111, 2'b00, 8'h00}));
    check("reset pins1", 32'(get_obs(1'b1)[15:0]), 32'({1'b0, 2'b00, 3'b111, 2'b00, 8'h00}));
    check("reset rsp_rdata", 32'({bus0.rsp_rdata, bus1.rsp_rdata}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("release idle0", 32'(get_obs(1'b0)), 32'(idle_obs(1'b0)));
    check("release idle1", 32'(get_obs(1'b1)), 32'(idle_obs(1'b1)));

    // ---- directed table ----
    vecs[0] = '{1'b0, 2'b00, 2'b01, 8'h0F, 8'h00, 8'h00, 1'b0, 5, 8'h00};
    vecs[1] = '{1'b0, 2'b01, 2'b11, 8'h00, 8'h2A, 8'h55, 1'b0, 5, 8'h2A};
    vecs[2] = '{1'b0, 2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 8'h2A};
    vecs[3] = '{1'b0, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 8'h2A};
    vecs[4] = '{1'b1, 2'b01, 2'b10, 8'h00, 8'hC3, 8'h3C, 1'b1, 7, 8'hC3};
    vecs[5] = '{1'b1, 2'b00, 2'b00, 8'hA5, 8'h11, 8'h22, 1'b1, 7, 8'hC3};
    vecs[6] = '{1'b0, 2'b00, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 5, 8'h2A};
    for (int i = 0; i < 7; i++)
      run_cmd(vecs[i].sel, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd_strobe,
              vecs[i].rd_hold, vecs[i].junk, vecs[i].exp_lat, vecs[i].exp_rsp,
              $sformatf("vec%0d", i));

    // ---- back-to-back with cmd_valid held high ----
    bop   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11};
    baddr = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    bdat  = '{8'd10, 8'd10, 8'd15, 8'd2, 8'd0, 8'd0};
    acc   = '{0, 0, 0, 0, 0, 0};
    idx = 0;
    pending = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, bop[0], baddr[0], bdat[0]);
    for (int n = 0; n < 60; n++) begin
      if (n > 0) @(negedge clk);
      ncs_q.push_back(bus0.ncs);
      start_q.push_back(bus0.start);
      if (pending) begin
        pending = 1'b0;
        idx++;
        if (idx < 6) drive(1'b0, 1'b1, bop[idx], baddr[idx], bdat[idx]);
        else drive(1'b0, 1'b0, 2'b00, 2'b00, 8'h00);
      end
      if (idx < 6 && bus0.cmd_ready && bus0.cmd_valid) begin
        acc[idx] = n;
        pending = 1'b1;
      end
    end
    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'h00);
    check("b2b accepted", 32'(idx), 32'd6);
    if (idx == 6) begin
      for (int i = 0; i < 4; i++) begin
        cnt = 0;
        for (int j = 1; j <= 4; j++) if (!ncs_q[acc[i] + j]) cnt++;
        check($sformatf("b2b spacing%0d", i), 32'(acc[i+1] - acc[i]), 32'd6);
        check($sformatf("b2b ncs%0d", i),
              32'({cnt[3:0], ncs_q[acc[i]], ncs_q[acc[i] + 5]}), 32'({4'd4, 2'b11}));
      end
      check("b2b start set", 32'({start_q[acc[4]], start_q[acc[4] + 1]}), 32'(2'b01));
      check("b2b start clr", 32'({start_q[acc[5]], start_q[acc[5] + 1]}), 32'(2'b10));
    end
    exp_start[0] = 1'b0;

    // ---- reset during the strobe of a write ----
    run_cmd(1'b0, 2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1, exp_rdata[0], "pre-rst set");
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 2'b10, 8'h5A);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 2'b00, 8'h00);
    @(negedge clk);
    check("rst strobe active", 32'({bus0.ncs, bus0.nwr}), 32'(2'b00));
    #2 reset = 1'b0;
    #1;
    check("rst async pins", 32'(get_obs(1'b0)[15:0]), 32'({1'b0, 2'b00, 3'b111, 2'b00, 8'h00}));
    exp_start = '{1'b0, 1'b0};
    exp_rdata = '{8'h00, 8'h00};
    cnt = 0;
    repeat (3) @(negedge clk) if (bus0.done) cnt++;
    reset = 1'b1;
    repeat (3) @(negedge clk) if (bus0.done) cnt++;
    check("rst no done", 32'(cnt), 32'd0);
    check("rst idle0", 32'(get_obs(1'b0)), 32'(idle_obs(1'b0)));
    check("rst rsp_rdata", 32'(bus0.rsp_rdata), 32'd0);

    // ---- randomized commands against the timeline model ----
    for (int r = 0; r < 40; r++) begin
      bit       sel;
      bit [1:0] op;
      bit [7:0] rds;
      sel = 1'($urandom);
      op  = 2'($urandom);
      rds = 8'($urandom);
      run_cmd(sel, op, 2'($urandom), 8'($urandom), rds, 8'($urandom), 1'($urandom),
              op[1] ? 1 : bus_len(sel) + 1, (op == 2'b01) ? rds : exp_rdata[sel],
              $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_bus_master.md
COUNTER_BUS_MASTER -- requirements
Module: counter_bus_master

Interface
REQ-001 Parameter SETUP_CYC, default 1, cycles of address/chip-select setup before the strobe (legal 1..15).
REQ-002 Parameter STROBE_CYC, default 2, cycles nwr/nrd is held low (legal 1..15).
REQ-003 Parameter HOLD_CYC, default 1, cycles address/data/ncs are held after the strobe rises (legal 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  engine can accept a command.
REQ-008 cmd_op  input  2  00 register write, 01 register read, 10 start set, 11 start clear.
REQ-009 cmd_addr  input  2  register address; bit0 drives A0, bit1 drives A1.
REQ-010 cmd_wdata  input  8  write data.
REQ-011 done  output  1  one-cycle pulse when a command completes (all ops).
REQ-012 rsp_valid  output  1  one-cycle pulse, read data valid (read ops only, coincident with done).
REQ-013 rsp_rdata  output  8  captured read data; holds until next read completes.
REQ-014 ncs, nwr, nrd  output  1 each  active-low chip select, write strobe, read strobe to the counter.
REQ-015 A0, A1  output  1 each  counter register address.
REQ-016 dout  output  8  write data to the counter's din.
REQ-017 bus_rdata  input  8  read data returned by the counter (its count bus).
REQ-018 start  output  1  level drive to the counter's start input.

Function
REQ-019 States: IDLE, SETUP, STROBE, HOLD, FINISH; 4-bit phase counter times SETUP/STROBE/HOLD.
REQ-020 cmd_ready is 1 only in IDLE; command accepted on the edge where cmd_valid && cmd_ready; cmd_op/addr/wdata are registered at acceptance and inputs are ignored thereafter.
REQ-021 Ops 10/11: IDLE -> FINISH; start set to 1 (10) or 0 (11) at acceptance; no bus activity; done next cycle.
REQ-022 Ops 00/01: IDLE -> SETUP (SETUP_CYC cycles) -> STROBE (STROBE_CYC cycles) -> HOLD (HOLD_CYC cycles) -> FINISH (1 cycle) -> IDLE.
REQ-023 ncs = 0 in SETUP, STROBE and HOLD; 1 otherwise.
REQ-024 A1/A0 = registered cmd_addr in SETUP through HOLD; 0 otherwise.
REQ-025 Write: nwr = 0 only in STROBE; dout = registered cmd_wdata in SETUP through HOLD, 0 otherwise; nrd stays 1.
REQ-026 Read: nrd = 0 only in STROBE; nwr stays 1; dout = 0; bus_rdata sampled into rsp_rdata on the rising edge ending the last STROBE cycle.
REQ-027 nwr and nrd are never both 0; strobes never low while ncs = 1.
REQ-028 All bus outputs are registered (glitch-free, change only on clk rising edge or reset).
REQ-029 done (and rsp_valid for reads) asserted during FINISH; bus cycle latency from acceptance edge to done = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles.
REQ-030 Back-to-back: a command presented during FINISH is not accepted; earliest next acceptance is the first IDLE cycle, giving at least one cycle with ncs = 1 between bus cycles.
REQ-031 start is unaffected by ops 00/01.

Reset
REQ-032 reset = 0 forces at once: state IDLE, phase counter 0, ncs = nwr = nrd = 1, A0 = A1 = 0, dout = 0, start = 0, cmd_ready = 1 (after reset release), done = rsp_valid = 0, rsp_rdata = 0.
REQ-033 Reset mid-cycle aborts the command: strobes and ncs deassert immediately, no done/rsp_valid is produced for it.

Verification
REQ-034 Defaults, write op 00, addr 2'b01, wdata 8'h0F -> ncs low 4 cycles, A1A0 = 01, nwr low exactly cycles 2-3 after acceptance, dout = 8'h0F throughout, done in cycle 5, rsp_valid stays 0.
REQ-035 Read op 01, addr 2'b11, bus_rdata = 8'h2A during STROBE changing to 8'h55 in HOLD -> rsp_rdata = 8'h2A, rsp_valid and done high together in cycle 5.
REQ-036 Four back-to-back writes (addr 00..11, data 10, 10, 15, 2) then op 10 with cmd_valid held high -> ncs high for ≥1 cycle between each bus cycle, start rises 1 cycle after the fifth acceptance; op 11 then returns start to 0.
REQ-037 Assert reset during STROBE of a write -> nwr and ncs go 1 without waiting for clk, no done, start = 0, cmd_ready = 1 after release.
REQ-038 SETUP_CYC = 3, STROBE_CYC = 1, HOLD_CYC = 2 read -> strobe low 1 cycle, done 7 cycles after acceptance; cmd_valid toggling during the cycle has no effect.
